sram_128x22_arb_ctrl: RTL and testbench

Two-requester arbiter and initialiser for the 128x22 single-port synchronous tag SRAM macro wrapper. After reset it walks all 128 entries and writes INIT_VAL. It then shares the single SRAM port between requester A and requester B with round-robin priority. It returns read data with a registered valid strobe. The block sits between the SRAM wrapper and the cache/fetch logic that owns the two requesters.

---
 rtl/sram_128x22_arb_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sram_128x22_arb_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_128x22_arb_ctrl.sv
// -----------------------------------------------------------------------------
// sram_128x22_arb_ctrl
//
// Purpose:
//   Arbiter and initialiser in front of the 128x22 single-port synchronous tag
//   SRAM wrapper. After reset it writes INIT_VAL into every entry, address 0
//   up to DEPTH-1, one entry per cycle. It then shares the single SRAM port
//   between requester A and requester B using round-robin priority. Read data
//   comes back one cycle after the grant, together with a registered valid
//   strobe.
//
// Ports:
//   CLK        clock; all state changes on the rising edge
//   RST        synchronous reset, active high
//   A_REQ      requester A access request (held until A_GNT is sampled high)
//   A_WR       requester A direction: 1 = write, 0 = read
//   A_ADDR     requester A address
//   A_WDATA    requester A write data
//   A_GNT      requester A access accepted this cycle (combinational)
//   A_RVALID   requester A read data valid (registered, one-cycle pulse)
//   A_RDATA    requester A read data; zero whenever A_RVALID is low
//   B_*        same set of ports for requester B
//   INIT_BUSY  init sweep in progress (or reset held); no grants issued
//   SRAM_ADDR  to wrapper ADDR
//   SRAM_WEN   to wrapper WEN, active-low write enable
//   SRAM_DIN   to wrapper DATA_IN
//   SRAM_DOUT  from wrapper DATA_OUT, valid the cycle after a read address
// -----------------------------------------------------------------------------
module sram_128x22_arb_ctrl #(
    parameter int              AW       = 7,
    parameter int              DW       = 22,
    parameter logic [DW-1:0]   INIT_VAL = {DW{1'b0}}
) (
    input  logic            CLK,
    input  logic            RST,

    input  logic            A_REQ,
    input  logic            A_WR,
    input  logic [AW-1:0]   A_ADDR,
    input  logic [DW-1:0]   A_WDATA,
    output logic            A_GNT,
    output logic            A_RVALID,
    output logic [DW-1:0]   A_RDATA,

    input  logic            B_REQ,
    input  logic            B_WR,
    input  logic [AW-1:0]   B_ADDR,
    input  logic [DW-1:0]   B_WDATA,
    output logic            B_GNT,
    output logic            B_RVALID,
    output logic [DW-1:0]   B_RDATA,

    output logic            INIT_BUSY,

    output logic [AW-1:0]   SRAM_ADDR,
    output logic            SRAM_WEN,
    output logic [DW-1:0]   SRAM_DIN,
    input  logic [DW-1:0]   SRAM_DOUT
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Priority pointer encoding: which requester wins when both ask.
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t          state_r;
    logic [AW-1:0]   init_cnt_r;
    logic            ptr_r;
    logic            a_rvalid_r;
    logic            b_rvalid_r;

    logic            a_win_s;
    logic            b_win_s;
    logic            run_s;

    // RST is folded in combinationally so that no grant and no SRAM write is
    // ever presented while reset is asserted, even on the first reset cycle
    // of a mid-operation reset when the state register still says RUN.
    assign run_s = (state_r == ST_RUN) && !RST;

    // Grant selection: lone requester always wins, a tie goes to the pointer.
    always_comb begin
        a_win_s = 1'b0;
        b_win_s = 1'b0;
        if (run_s) begin
            case ({A_REQ, B_REQ})
                2'b10: begin
                    a_win_s = 1'b1;
                end
                2'b01: begin
                    b_win_s = 1'b1;
                end
                2'b11: begin
                    if (ptr_r == PTR_A) begin
                        a_win_s = 1'b1;
                    end else begin
                        b_win_s = 1'b1;
                    end
                end
                default: begin
                    a_win_s = 1'b0;
                    b_win_s = 1'b0;
                end
            endcase
        end else begin
            a_win_s = 1'b0;
            b_win_s = 1'b0;
        end
    end

    // SRAM port drive: idle in reset, sweep during init, winner during run.
    always_comb begin
        SRAM_ADDR = {AW{1'b0}};
        SRAM_DIN  = {DW{1'b0}};
        SRAM_WEN  = 1'b1;
        if (RST) begin
            SRAM_ADDR = {AW{1'b0}};
            SRAM_DIN  = {DW{1'b0}};
            SRAM_WEN  = 1'b1;
        end else if (state_r == ST_INIT) begin
            SRAM_ADDR = init_cnt_r;
            SRAM_DIN  = INIT_VAL;
            SRAM_WEN  = 1'b0;
        end else if (a_win_s) begin
            SRAM_ADDR = A_ADDR;
            SRAM_DIN  = A_WDATA;
            SRAM_WEN  = ~A_WR;
        end else if (b_win_s) begin
            SRAM_ADDR = B_ADDR;
            SRAM_DIN  = B_WDATA;
            SRAM_WEN  = ~B_WR;
        end else begin
            SRAM_ADDR = {AW{1'b0}};
            SRAM_DIN  = {DW{1'b0}};
            SRAM_WEN  = 1'b1;
        end
    end

    // Controller state: init/run FSM, sweep counter, priority pointer and
    // the read-valid strobes that follow a granted read by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {AW{1'b0}};
            ptr_r      <= PTR_A;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    // Counter wraps to zero on the same edge that enters RUN.
                    init_cnt_r <= init_cnt_r + CNT_ONE;
                    if (init_cnt_r == CNT_LAST) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_RUN: begin
                    init_cnt_r <= init_cnt_r;
                    state_r    <= ST_RUN;
                end
                default: begin
                    init_cnt_r <= {AW{1'b0}};
                    state_r    <= ST_INIT;
                end
            endcase

            // After any grant the other requester holds priority.
            if (a_win_s) begin
                ptr_r <= PTR_B;
            end else if (b_win_s) begin
                ptr_r <= PTR_A;
            end else begin
                ptr_r <= ptr_r;
            end

            a_rvalid_r <= a_win_s && !A_WR;
            b_rvalid_r <= b_win_s && !B_WR;
        end
    end

    assign A_GNT     = a_win_s;
    assign B_GNT     = b_win_s;
    assign A_RVALID  = a_rvalid_r;
    assign B_RVALID  = b_rvalid_r;
    // The wrapper output is only meaningful in the cycle after a read grant,
    // so it is masked to zero everywhere else.
    assign A_RDATA   = a_rvalid_r ? SRAM_DOUT : {DW{1'b0}};
    assign B_RDATA   = b_rvalid_r ? SRAM_DOUT : {DW{1'b0}};
    assign INIT_BUSY = RST || (state_r == ST_INIT);

endmodule

// File: tb/tb_sram_128x22_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_128x22_arb_ctrl
//
// Directed testbench for sram_128x22_arb_ctrl. A behavioural 128x22
// synchronous SRAM sits on the wrapper side of the design. Inputs change 1
// time unit after the rising edge, and outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_sram_128x22_arb_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        A_REQ, A_WR, A_GNT, A_RVALID;
    logic [6:0]  A_ADDR;
    logic [21:0] A_WDATA, A_RDATA;
    logic        B_REQ, B_WR, B_GNT, B_RVALID;
    logic [6:0]  B_ADDR;
    logic [21:0] B_WDATA, B_RDATA;
    logic        INIT_BUSY;
    logic [6:0]  SRAM_ADDR;
    logic        SRAM_WEN;
    logic [21:0] SRAM_DIN, SRAM_DOUT;

    logic [21:0] mem [128];

    int total = 0;
    int bad   = 0;

    localparam logic [21:0] D_AAA = 22'h2AAAAA;
    localparam logic [21:0] D_555 = 22'h155555;

    always #5 CLK = ~CLK;

    sram_128x22_arb_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .A_REQ     (A_REQ),
        .A_WR      (A_WR),
        .A_ADDR    (A_ADDR),
        .A_WDATA   (A_WDATA),
        .A_GNT     (A_GNT),
        .A_RVALID  (A_RVALID),
        .A_RDATA   (A_RDATA),
        .B_REQ     (B_REQ),
        .B_WR      (B_WR),
        .B_ADDR    (B_ADDR),
        .B_WDATA   (B_WDATA),
        .B_GNT     (B_GNT),
        .B_RVALID  (B_RVALID),
        .B_RDATA   (B_RDATA),
        .INIT_BUSY (INIT_BUSY),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WEN  (SRAM_WEN),
        .SRAM_DIN  (SRAM_DIN),
        .SRAM_DOUT (SRAM_DOUT)
    );

    // Behavioural single-port synchronous SRAM (registered read data).
    always @(posedge CLK) begin
        if (!SRAM_WEN) mem[SRAM_ADDR] <= SRAM_DIN;
        SRAM_DOUT <= mem[SRAM_ADDR];
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 7'h7F;
        step();
        step();
        sample();
        total++; if (INIT_BUSY !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", INIT_BUSY); end
        total++; if (A_GNT !== 1'b0) begin bad++; $display("FAIL rst_a_gnt: got %b want 0", A_GNT); end
        total++; if (B_GNT !== 1'b0) begin bad++; $display("FAIL rst_b_gnt: got %b want 0", B_GNT); end
        total++; if (SRAM_WEN !== 1'b1) begin bad++; $display("FAIL rst_wen: got %b want 1", SRAM_WEN); end
        total++; if (SRAM_ADDR !== 7'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", SRAM_ADDR); end
        total++; if (SRAM_DIN !== 22'h0) begin bad++; $display("FAIL rst_din: got %h want 0", SRAM_DIN); end
        total++; if (A_RVALID !== 1'b0 || B_RVALID !== 1'b0) begin
            bad++; $display("FAIL rst_rvalid: got a=%b b=%b want 0 0", A_RVALID, B_RVALID);
        end
        step();
        RST = 1'b0;
        A_REQ = 1'b0;
    endtask

    task automatic test_init_sweep();
        logic [6:0] exp_addr;
        for (int i = 0; i < 128; i++) begin
            exp_addr = 7'(i);
            sample();
            total++; if (INIT_BUSY !== 1'b1 || SRAM_WEN !== 1'b0 || SRAM_ADDR !== exp_addr || SRAM_DIN !== 22'h0) begin
                bad++;
                $display("FAIL sweep_%0d: got busy=%b wen=%b addr=%h din=%h want 1 0 %h 0",
                         i, INIT_BUSY, SRAM_WEN, SRAM_ADDR, SRAM_DIN, exp_addr);
            end
            step();
        end
        A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 7'h7F;
        sample();
        total++; if (INIT_BUSY !== 1'b0) begin bad++; $display("FAIL sweep_end_busy: got %b want 0", INIT_BUSY); end
        total++; if (A_GNT !== 1'b1 || SRAM_ADDR !== 7'h7F || SRAM_WEN !== 1'b1) begin
            bad++; $display("FAIL sweep_rd_gnt: got gnt=%b addr=%h wen=%b want 1 7f 1", A_GNT, SRAM_ADDR, SRAM_WEN);
        end
        step();
        A_REQ = 1'b0;
        sample();
        total++; if (A_RVALID !== 1'b1 || A_RDATA !== 22'h0) begin
            bad++; $display("FAIL sweep_rd_data: got v=%b d=%h want 1 0", A_RVALID, A_RDATA);
        end
        step();
        sample();
        total++; if (A_RVALID !== 1'b0) begin bad++; $display("FAIL sweep_rd_pulse: got %b want 0", A_RVALID); end
        step();
    endtask

    task automatic test_write_read();
        A_REQ = 1'b1; A_WR = 1'b1; A_ADDR = 7'h7F; A_WDATA = D_AAA;
        sample();
        total++; if (A_GNT !== 1'b1 || SRAM_WEN !== 1'b0 || SRAM_DIN !== D_AAA) begin
            bad++; $display("FAIL wr_gnt: got gnt=%b wen=%b din=%h want 1 0 %h", A_GNT, SRAM_WEN, SRAM_DIN, D_AAA);
        end
        step();
        A_WR = 1'b0;
        sample();
        total++; if (A_GNT !== 1'b1 || A_RVALID !== 1'b0) begin
            bad++; $display("FAIL rd_gnt: got gnt=%b v=%b want 1 0", A_GNT, A_RVALID);
        end
        step();
        A_REQ = 1'b0;
        sample();
        total++; if (A_RVALID !== 1'b1 || A_RDATA !== D_AAA) begin
            bad++; $display("FAIL wr_rd_data: got v=%b d=%h want 1 %h", A_RVALID, A_RDATA, D_AAA);
        end
        step();
    endtask

    task automatic test_b_write_a_read();
        B_REQ = 1'b1; B_WR = 1'b1; B_ADDR = 7'h05; B_WDATA = D_555;
        sample();
        total++; if (B_GNT !== 1'b1 || A_GNT !== 1'b0 || SRAM_WEN !== 1'b0 || SRAM_DIN !== D_555) begin
            bad++; $display("FAIL bwr_gnt: got b=%b a=%b wen=%b din=%h want 1 0 0 %h", B_GNT, A_GNT, SRAM_WEN, SRAM_DIN, D_555);
        end
        step();
        B_REQ = 1'b0;
        A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 7'h05;
        sample();
        total++; if (A_GNT !== 1'b1 || B_RVALID !== 1'b0) begin
            bad++; $display("FAIL ard_gnt: got a=%b bv=%b want 1 0", A_GNT, B_RVALID);
        end
        step();
        // both request: B holds the pointer after A's grant
        A_ADDR = 7'h7F;
        B_REQ = 1'b1; B_WR = 1'b0; B_ADDR = 7'h05;
        sample();
        total++; if (A_RVALID !== 1'b1 || A_RDATA !== D_555) begin
            bad++; $display("FAIL ard_data: got v=%b d=%h want 1 %h", A_RVALID, A_RDATA, D_555);
        end
        total++; if (B_GNT !== 1'b1 || A_GNT !== 1'b0) begin
            bad++; $display("FAIL ptr_b: got b=%b a=%b want 1 0", B_GNT, A_GNT);
        end
        step();
        A_REQ = 1'b0; B_REQ = 1'b0;
        sample();
        total++; if (B_RVALID !== 1'b1 || B_RDATA !== D_555 || A_RVALID !== 1'b0) begin
            bad++; $display("FAIL brd_data: got bv=%b bd=%h av=%b want 1 %h 0", B_RVALID, B_RDATA, A_RVALID, D_555);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic exp_ag, exp_av;
        for (int k = 0; k < 7; k++) begin
            A_REQ = (k < 6); A_WR = 1'b0; A_ADDR = 7'h7F;
            B_REQ = (k < 6); B_WR = 1'b0; B_ADDR = 7'h05;
            sample();
            exp_ag = (k % 2 == 0);
            if (k < 6) begin
                total++; if (A_GNT !== exp_ag || B_GNT !== !exp_ag) begin
                    bad++; $display("FAIL rr_gnt_%0d: got a=%b b=%b want %b %b", k, A_GNT, B_GNT, exp_ag, !exp_ag);
                end
            end
            if (k == 0) begin
                total++; if (A_RVALID !== 1'b0 || B_RVALID !== 1'b0) begin
                    bad++; $display("FAIL rr_v_0: got a=%b b=%b want 0 0", A_RVALID, B_RVALID);
                end
            end else begin
                exp_av = ((k - 1) % 2 == 0);
                total++; if (A_RVALID !== exp_av || B_RVALID !== !exp_av) begin
                    bad++; $display("FAIL rr_v_%0d: got a=%b b=%b want %b %b", k, A_RVALID, B_RVALID, exp_av, !exp_av);
                end
                total++; if (A_RDATA !== (exp_av ? D_AAA : 22'h0) || B_RDATA !== (exp_av ? 22'h0 : D_555)) begin
                    bad++; $display("FAIL rr_d_%0d: got a=%h b=%h", k, A_RDATA, B_RDATA);
                end
            end
            step();
        end
    endtask

    task automatic test_rst_during_read();
        int n;
        A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 7'h05;
        RST = 1'b1;
        step();
        RST = 1'b0; A_REQ = 1'b0;
        sample();
        total++; if (A_RVALID !== 1'b0 || A_GNT !== 1'b0 || INIT_BUSY !== 1'b1) begin
            bad++; $display("FAIL rstrd_next: got v=%b gnt=%b busy=%b want 0 0 1", A_RVALID, A_GNT, INIT_BUSY);
        end
        n = 0;
        while (INIT_BUSY === 1'b1 && n < 300) begin
            n++;
            step();
            sample();
        end
        total++; if (n != 128) begin bad++; $display("FAIL rstrd_sweep_len: got %0d want 128", n); end
        A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 7'h05;
        #1;
        total++; if (A_GNT !== 1'b1) begin bad++; $display("FAIL rstrd_gnt: got %b want 1", A_GNT); end
        step();
        A_REQ = 1'b0;
        sample();
        total++; if (A_RVALID !== 1'b1 || A_RDATA !== 22'h0) begin
            bad++; $display("FAIL rstrd_data: got v=%b d=%h want 1 0", A_RVALID, A_RDATA);
        end
        step();
    endtask

    task automatic test_req_during_init();
        logic [6:0] exp_addr;
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 128; i++) begin
            exp_addr = 7'(i);
            if (i == 10) begin
                A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 7'h7F;
            end
            sample();
            total++; if (A_GNT !== 1'b0 || SRAM_WEN !== 1'b0 || SRAM_ADDR !== exp_addr) begin
                bad++; $display("FAIL initreq_%0d: got gnt=%b wen=%b addr=%h want 0 0 %h", i, A_GNT, SRAM_WEN, SRAM_ADDR, exp_addr);
            end
            step();
        end
        sample();
        total++; if (A_GNT !== 1'b1 || INIT_BUSY !== 1'b0) begin
            bad++; $display("FAIL initreq_run: got gnt=%b busy=%b want 1 0", A_GNT, INIT_BUSY);
        end
        step();
        A_REQ = 1'b0;
        sample();
        total++; if (A_RVALID !== 1'b1 || A_RDATA !== 22'h0) begin
            bad++; $display("FAIL initreq_data: got v=%b d=%h want 1 0", A_RVALID, A_RDATA);
        end
        step();
    endtask

    initial begin
        RST = 1'b1;
        A_REQ = 1'b0; A_WR = 1'b0; A_ADDR = 7'h00; A_WDATA = 22'h0;
        B_REQ = 1'b0; B_WR = 1'b0; B_ADDR = 7'h00; B_WDATA = 22'h0;
        test_reset();
        test_init_sweep();
        test_write_read();
        test_b_write_a_read();
        test_round_robin();
        test_rst_during_read();
        test_req_during_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
